// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end constants.
// Fetch and the instruction queue both size themselves from IQ_DEPTH.
package cpu_defs;
    localparam int INST_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int IQ_DEPTH = 16;
endpackage

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode.
// Flush empties it, emits a one-cycle redirect PC and squashes in-flight pushes.
module inst_queue
    import cpu_defs::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              full,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              overflow
);

    localparam logic [PTR_W:0] DEPTH_C    = (PTR_W + 1)'(DEPTH);
    localparam logic [1:0]     SQUASH_LEN = 2'd2;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [1:0]        squash_q, squash_d;
    logic [ADDR_W-1:0] redirect_q, redirect_d;
    logic              overflow_q, overflow_d;

    logic live_push;
    logic push_en;
    logic pop_en;

    assign out_valid   = (count_q != '0);
    assign out_inst    = inst_mem[head_q];
    assign out_pc      = pc_mem[head_q];
    assign full        = (count_q >= DEPTH_C - 1'b1);
    assign redirect_pc = redirect_q;
    assign overflow    = overflow_q;

    // A push outside the squash window; it only lands if there is room.
    assign live_push = in_valid && (squash_q == 2'd0);
    assign push_en   = !flush && live_push && (count_q != DEPTH_C);
    assign pop_en    = !flush && out_valid && out_ready;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        squash_d   = squash_q;
        redirect_d = '0;
        overflow_d = overflow_q;
        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            squash_d   = SQUASH_LEN;
            redirect_d = flush_pc;
        end else begin
            if (squash_q != 2'd0) begin
                squash_d = squash_q - 2'd1;
            end
            if (live_push && count_q == DEPTH_C) begin
                overflow_d = 1'b1;
            end
            if (push_en) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop_en) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W + 1)'(push_en)
                              - (PTR_W + 1)'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            squash_q   <= '0;
            redirect_q <= '0;
            overflow_q <= 1'b0;
        end else if (rdy) begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            squash_q   <= squash_d;
            redirect_q <= redirect_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && rdy && push_en) begin
            inst_mem[tail_q] <= in_inst;
            pc_mem[tail_q]   <= in_pc;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue at DEPTH=4.
// Stimulus queues expected PCs; a negedge monitor checks every pop.
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        full;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q [$];

    inst_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .in_valid   (in_valid),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .full       (full),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input bit accepted);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst_of(pc);
        if (accepted) exp_q.push_back(pc);
        step();
    endtask

    // Monitor: every real pop must match the oldest expected entry.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && rdy && !flush && out_valid && out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got pc %h expected none",
                         out_pc);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e || out_inst !== inst_of(e)) begin
                    n_fail++;
                    $display("FAIL pop: got pc %h inst %h expected pc %h inst %h",
                             out_pc, out_inst, e, inst_of(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        rdy       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        flush_pc  = '0;
        step();
        step();
        rst = 1'b0;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Fill with decoder stalled
        push(32'h0, 1'b1);
        chk("fill1_visible", 32'(out_valid), 32'd1);
        chk("fill1_full", 32'(full), 32'd0);
        push(32'h4, 1'b1);
        chk("fill2_full", 32'(full), 32'd0);
        push(32'h8, 1'b1);
        chk("fill3_full", 32'(full), 32'd1);
        push(32'hC, 1'b1);
        chk("fill4_full", 32'(full), 32'd1);
        chk("fill4_overflow", 32'(overflow), 32'd0);
        push(32'h10, 1'b0);
        chk("fill5_overflow", 32'(overflow), 32'd1);
        in_valid = 1'b0;

        // Drain
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_full", 32'(full), 32'd0);
        chk("drain_left", 32'(exp_q.size()), 32'd0);

        // Wrap: push and pop every cycle
        for (int i = 0; i < 10; i++) begin
            push(32'h100 + 32'(4 * i), 1'b1);
            chk("wrap_valid", 32'(out_valid), 32'd1);
            chk("wrap_full", 32'(full), 32'd0);
        end
        in_valid = 1'b0;
        step();
        chk("wrap_empty", 32'(out_valid), 32'd0);
        chk("wrap_left", 32'(exp_q.size()), 32'd0);

        // Flush with a push in the same cycle
        out_ready = 1'b0;
        push(32'h200, 1'b1);
        push(32'h204, 1'b1);
        push(32'h208, 1'b1);
        flush    = 1'b1;
        flush_pc = 32'h80;
        in_pc    = 32'h20C;
        in_inst  = inst_of(32'h20C);
        exp_q.delete();
        step();
        flush = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_redirect", redirect_pc, 32'h80);
        push(32'h10, 1'b0);
        chk("flush_redirect_clr", redirect_pc, 32'd0);
        chk("squash1_valid", 32'(out_valid), 32'd0);
        push(32'h14, 1'b0);
        chk("squash2_valid", 32'(out_valid), 32'd0);
        push(32'h80, 1'b1);
        in_valid = 1'b0;
        chk("post_flush_valid", 32'(out_valid), 32'd1);
        chk("post_flush_pc", out_pc, 32'h80);
        out_ready = 1'b1;
        step();
        chk("post_flush_empty", 32'(out_valid), 32'd0);

        // Global stall
        out_ready = 1'b0;
        push(32'h300, 1'b1);
        push(32'h304, 1'b1);
        rdy       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h308;
        in_inst   = inst_of(32'h308);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_head", out_pc, 32'h300);
            chk("stall_redirect", redirect_pc, 32'd0);
        end
        in_valid = 1'b0;
        rdy      = 1'b1;
        step();
        chk("resume_head", out_pc, 32'h304);
        step();
        chk("resume_empty", 32'(out_valid), 32'd0);

        // Reset mid-operation inside a squash window
        out_ready = 1'b0;
        push(32'h400, 1'b1);
        push(32'h404, 1'b1);
        push(32'h408, 1'b1);
        in_valid = 1'b0;
        flush    = 1'b1;
        flush_pc = 32'h500;
        exp_q.delete();
        step();
        flush = 1'b0;
        chk("flush2_redirect", redirect_pc, 32'h500);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_full", 32'(full), 32'd0);
        chk("rst2_redirect", redirect_pc, 32'd0);
        chk("rst2_overflow", 32'(overflow), 32'd0);
        push(32'h600, 1'b1);
        in_valid = 1'b0;
        chk("rst2_push_valid", 32'(out_valid), 32'd1);
        chk("rst2_push_pc", out_pc, 32'h600);
        out_ready = 1'b1;
        step();
        chk("final_left", 32'(exp_q.size()), 32'd0);
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
